// File: rtl/calc_key_pkg.sv
// Shared keypad definitions: scanner states, key code constants and the
// row/column to key code map. Also used by the downstream input controller.
package calc_key_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } key_state_e;

   localparam logic [3:0] KEY_EQ     = 4'hE;
   localparam logic [3:0] KEY_CLR    = 4'hF;
   localparam logic [3:0] KEY_OP_MIN = 4'hA;
   localparam logic [3:0] KEY_OP_MAX = 4'hD;

   // Number of low (active) lines in an active-low 4-bit vector.
   function automatic logic [2:0] zero_cnt(input logic [3:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) n = n + {2'b00, ~v[i]};
      return n;
   endfunction

   // Index of the lowest low bit; meaningful when exactly one bit is low.
   function automatic logic [1:0] cold_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) if (!v[i]) idx = 2'(i);
      return idx;
   endfunction

   // Physical key position to code (r3 row holds clear, zero, equals, D).
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;
         4'h1: k = 4'h2;
         4'h2: k = 4'h3;
         4'h3: k = KEY_OP_MIN;
         4'h4: k = 4'h4;
         4'h5: k = 4'h5;
         4'h6: k = 4'h6;
         4'h7: k = 4'hB;
         4'h8: k = 4'h7;
         4'h9: k = 4'h8;
         4'hA: k = 4'h9;
         4'hB: k = 4'hC;
         4'hC: k = KEY_CLR;
         4'hD: k = 4'h0;
         4'hE: k = KEY_EQ;
         default: k = KEY_OP_MAX;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Saturating stable-sample counter shared by press and release debouncing.
// done is high on the sample that brings the count to DEB_CNT, so the
// registered consequence lands on the following cycle.
module key_debounce #(
   parameter int DEB_CNT = 20
) (
   input  logic CLK_1K,
   input  logic RST,
   input  logic sample,
   input  logic match,
   input  logic clear,
   output logic done
);

   localparam int CW = $clog2(DEB_CNT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear wins, a mismatching sample restarts, saturate at DEB_CNT.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (sample) begin
         if (!match)
            cnt_d = '0;
         else if (cnt_q != CW'(DEB_CNT))
            cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge CLK_1K or negedge RST) begin
      if (!RST) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign done = sample && match && !clear && (cnt_q >= CW'(DEB_CNT - 1));

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner/debouncer on the 1 kHz tick. Drives one-cold columns,
// synchronizes rows, debounces press and release and strobes flag once per
// accepted key. Optional auto-repeat of digit keys: define KEY_REPEAT_EN.
module key_scan
   import calc_key_pkg::*;
#(
   parameter int DEB_CNT    = 20,
   parameter int SCAN_DWELL = 3,
   parameter int REPEAT_DLY = 500,
   parameter int REPEAT_PER = 100
) (
   input  logic       CLK_1K,
   input  logic       RST,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_value,
   output logic       flag
);

   localparam int DW = $clog2(SCAN_DWELL);

   key_state_e    state_q, state_d;
   logic [3:0]    sync_q, row_s;
   logic [3:0]    col_q, col_d;
   logic [3:0]    pat_q, pat_d;
   logic [3:0]    kv_q, kv_d;
   logic          flag_q, flag_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic          deb_sample, deb_match, deb_clear, deb_done;
   logic          rep_fire;

   // Two-flop synchronizer for the asynchronous row lines (idle high).
   always_ff @(posedge CLK_1K or negedge RST) begin
      if (!RST) begin
         sync_q <= 4'hF;
         row_s  <= 4'hF;
      end else begin
         sync_q <= row;
         row_s  <= sync_q;
      end
   end

   key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .CLK_1K (CLK_1K),
      .RST    (RST),
      .sample (deb_sample),
      .match  (deb_match),
      .clear  (deb_clear),
      .done   (deb_done)
   );

   // Scan/debounce FSM next state and outputs.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      dwell_d    = dwell_q;
      pat_d      = pat_q;
      kv_d       = kv_q;
      flag_d     = 1'b0;
      deb_sample = 1'b0;
      deb_match  = 1'b0;
      deb_clear  = 1'b0;
      case (state_q)
         SCAN: begin
            deb_clear = 1'b1;
            if (dwell_q == DW'(SCAN_DWELL - 1)) begin
               dwell_d = '0;
               if (zero_cnt(row_s) == 3'd1) begin
                  pat_d   = row_s;
                  state_d = DEBOUNCE;
               end else if (row_s == 4'hF)
                  col_d = {col_q[2:0], col_q[3]};
               else
                  state_d = RELEASE;   // ghosting risk: wait for all keys up
            end else
               dwell_d = dwell_q + 1'b1;
         end
         DEBOUNCE: begin
            deb_sample = 1'b1;
            deb_match  = (row_s == pat_q);
            if (!deb_match)
               state_d = SCAN;         // column stays frozen, dwell restarts
            else if (deb_done) begin
               kv_d    = key_code(cold_idx(pat_q), cold_idx(col_q));
               flag_d  = 1'b1;
               state_d = HELD;
            end
         end
         HELD: begin
            deb_clear = 1'b1;
            if (row_s == 4'hF)
               state_d = RELEASE;
            else if (rep_fire)
               flag_d = 1'b1;
         end
         default: begin                // RELEASE
            deb_sample = 1'b1;
            deb_match  = (row_s == 4'hF);
            if (deb_done) state_d = SCAN;
         end
      endcase
   end

   // FSM and datapath registers.
   always_ff @(posedge CLK_1K or negedge RST) begin
      if (!RST) begin
         state_q <= SCAN;
         col_q   <= 4'b1110;
         dwell_q <= '0;
         pat_q   <= 4'hF;
         kv_q    <= 4'h0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         dwell_q <= dwell_d;
         pat_q   <= pat_d;
         kv_q    <= kv_d;
         flag_q  <= flag_d;
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int HW   = $clog2(RMAX + 1);

   logic [HW-1:0] hold_q, hold_d;
   logic          rep_q, rep_d;

   // Hold timer: first repeat after REPEAT_DLY, then every REPEAT_PER; digits only.
   always_comb begin
      hold_d   = hold_q;
      rep_d    = rep_q;
      rep_fire = 1'b0;
      if (state_q != HELD) begin
         hold_d = '0;
         rep_d  = 1'b0;
      end else if (row_s != 4'hF && kv_q < KEY_OP_MIN) begin
         if (hold_q >= (rep_q ? HW'(REPEAT_PER - 1) : HW'(REPEAT_DLY - 1))) begin
            rep_fire = 1'b1;
            hold_d   = '0;
            rep_d    = 1'b1;
         end else
            hold_d = hold_q + 1'b1;
      end
   end

   // Hold timer registers.
   always_ff @(posedge CLK_1K or negedge RST) begin
      if (!RST) begin
         hold_q <= '0;
         rep_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         rep_q  <= rep_d;
      end
   end
`else
   // Repeat timing parameters only matter when auto-repeat is built in.
   logic unused_rep;
   assign unused_rep = ^{REPEAT_DLY, REPEAT_PER};
   assign rep_fire   = 1'b0;
`endif

   assign col       = col_q;
   assign key_value = kv_q;
   assign flag      = flag_q;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan: keypad model built from a pressed-key matrix.
module tb_key_scan;

   logic       CLK_1K = 1'b0;
   logic       RST    = 1'b0;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_value;
   logic       flag;
   logic [3:0][3:0] keys = '0;   // keys[r][c] = 1 while pressed

   int vec  = 0;
   int miss = 0;

   always #5 CLK_1K = ~CLK_1K;

   // A pressed key pulls its row low while its column is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r][c] && !col[c]) row[r] = 1'b0;
   end

   key_scan dut (
      .CLK_1K    (CLK_1K),
      .RST       (RST),
      .row       (row),
      .col       (col),
      .key_value (key_value),
      .flag      (flag)
   );

   task automatic tick();
      @(posedge CLK_1K);
      #1;
   endtask

   // Bounded wait for a column pattern; a timeout counts as a miscompare.
   task automatic wait_col(input logic [3:0] target);
      int n = 0;
      while (col !== target && n < 50) begin
         tick();
         n++;
      end
      vec++;
      if (col !== target) begin
         miss++;
         $display("FAIL wait_col: col=%b required %b", col, target);
      end
   endtask

   task automatic test_reset();
      RST  = 1'b0;
      keys = '0;
      repeat (3) tick();
      vec++; if (col !== 4'b1110) begin miss++; $display("FAIL reset_col: %b required 1110", col); end
      vec++; if (flag !== 1'b0) begin miss++; $display("FAIL reset_flag: %b required 0", flag); end
      vec++; if (key_value !== 4'h0) begin miss++; $display("FAIL reset_kv: %h required 0", key_value); end
      RST = 1'b1;
   endtask

   task automatic test_idle();
      int nflag = 0;
      logic [3:0] exp_col;
      for (int k = 1; k < 100; k++) begin
         tick();
         exp_col = ~(4'b0001 << ((k / 3) % 4));
         if (flag) nflag++;
         vec++;
         if (col !== exp_col) begin
            miss++;
            $display("FAIL idle_col cycle %0d: %b required %b", k, col, exp_col);
         end
      end
      vec++; if (nflag !== 0) begin miss++; $display("FAIL idle_flags: %0d required 0", nflag); end
      vec++; if (key_value !== 4'h0) begin miss++; $display("FAIL idle_kv: %h required 0", key_value); end
   endtask

   task automatic test_clean_press();
      int nflag = 0, first = 0;
      logic after = 1'b1;
      wait_col(4'b0111);
      keys[1][2] = 1'b1;
      wait_col(4'b1011);
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (first != 0 && n == first + 1) after = flag;
         if (flag) begin
            nflag++;
            if (first == 0) first = n;
         end
      end
      keys = '0;
      repeat (40) begin tick(); if (flag) nflag++; end
      vec++; if (first !== 23) begin miss++; $display("FAIL clean_latency: %0d required 23", first); end
      vec++; if (after !== 1'b0) begin miss++; $display("FAIL clean_width: flag after pulse %b required 0", after); end
      vec++; if (nflag !== 1) begin miss++; $display("FAIL clean_count: %0d required 1", nflag); end
      vec++; if (key_value !== 4'h6) begin miss++; $display("FAIL clean_kv: %h required 6", key_value); end
   endtask

   task automatic test_bounce();
      int nflag = 0;
      wait_col(4'b1101);
      for (int i = 0; i < 5; i++) begin
         keys[3][2] = (i % 2 == 0);
         tick(); if (flag) nflag++;
      end
      keys[3][2] = 1'b1;
      repeat (60) begin tick(); if (flag) nflag++; end
      for (int i = 0; i < 5; i++) begin
         keys[3][2] = (i % 2 == 1);
         tick(); if (flag) nflag++;
      end
      keys = '0;
      repeat (50) begin tick(); if (flag) nflag++; end
      vec++; if (nflag !== 1) begin miss++; $display("FAIL bounce_count: %0d required 1", nflag); end
      vec++; if (key_value !== 4'hE) begin miss++; $display("FAIL bounce_kv: %h required E", key_value); end
   endtask

   task automatic test_multi_key();
      int nflag = 0;
      wait_col(4'b0111);
      keys[0][0] = 1'b1;
      keys[2][0] = 1'b1;
      repeat (40) begin tick(); if (flag) nflag++; end
      vec++; if (nflag !== 0) begin miss++; $display("FAIL multi_flags: %0d required 0", nflag); end
      vec++; if (key_value !== 4'hE) begin miss++; $display("FAIL multi_kv_hold: %h required E", key_value); end
      keys = '0;
      repeat (40) begin tick(); if (flag) nflag++; end
      keys[0][0] = 1'b1;
      repeat (60) begin tick(); if (flag) nflag++; end
      keys = '0;
      repeat (40) begin tick(); if (flag) nflag++; end
      vec++; if (nflag !== 1) begin miss++; $display("FAIL single_after_multi: %0d required 1", nflag); end
      vec++; if (key_value !== 4'h1) begin miss++; $display("FAIL single_kv: %h required 1", key_value); end
   endtask

   task automatic test_reset_mid();
      int nflag = 0;
      wait_col(4'b0111);
      keys[1][2] = 1'b1;
      wait_col(4'b1011);
      repeat (10) tick();
      vec++; if (col !== 4'b1011) begin miss++; $display("FAIL debounce_freeze: col=%b required 1011", col); end
      RST = 1'b0;
      #1;
      vec++; if (col !== 4'b1110) begin miss++; $display("FAIL rstmid_col: %b required 1110", col); end
      vec++; if (key_value !== 4'h0) begin miss++; $display("FAIL rstmid_kv: %h required 0", key_value); end
      vec++; if (flag !== 1'b0) begin miss++; $display("FAIL rstmid_flag: %b required 0", flag); end
      keys = '0;
      tick();
      RST = 1'b1;
      tick();
      vec++; if (col !== 4'b1110) begin miss++; $display("FAIL rstmid_restart: col=%b required 1110", col); end
      repeat (40) begin tick(); if (flag) nflag++; end
      vec++; if (nflag !== 0) begin miss++; $display("FAIL rstmid_flags: %0d required 0", nflag); end
   endtask

`ifdef KEY_REPEAT_EN
   task automatic test_repeat();
      int nflag = 0;
      int pos[4] = '{0, 0, 0, 0};
      wait_col(4'b1110);
      keys[2][1] = 1'b1;
      wait_col(4'b1101);
      for (int n = 1; n <= 700; n++) begin
         tick();
         if (flag) begin
            if (nflag < 4) pos[nflag] = n;
            nflag++;
         end
      end
      keys = '0;
      repeat (40) begin tick(); if (flag) nflag++; end
      vec++; if (nflag !== 3) begin miss++; $display("FAIL repeat_count: %0d required 3", nflag); end
      vec++; if (pos[0] !== 23) begin miss++; $display("FAIL repeat_first: %0d required 23", pos[0]); end
      vec++; if (pos[1] !== 523) begin miss++; $display("FAIL repeat_second: %0d required 523", pos[1]); end
      vec++; if (pos[2] !== 623) begin miss++; $display("FAIL repeat_third: %0d required 623", pos[2]); end
      vec++; if (key_value !== 4'h8) begin miss++; $display("FAIL repeat_kv: %h required 8", key_value); end
      nflag = 0;
      wait_col(4'b1110);
      keys[0][3] = 1'b1;
      repeat (740) begin tick(); if (flag) nflag++; end
      keys = '0;
      repeat (40) begin tick(); if (flag) nflag++; end
      vec++; if (nflag !== 1) begin miss++; $display("FAIL norepeat_op: %0d required 1", nflag); end
      vec++; if (key_value !== 4'hA) begin miss++; $display("FAIL norepeat_kv: %h required A", key_value); end
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_idle();
      test_clean_press();
      test_bounce();
      test_multi_key();
      test_reset_mid();
`ifdef KEY_REPEAT_EN
      test_repeat();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
